box_shape_drawer: RTL and testbench



---
 rtl/box_shape_drawer_pkg.sv | 24 ++
 rtl/box_shape_drawer_raster_counter.sv | 76 +++++++
 rtl/box_shape_drawer.sv | 154 +++++++++++++++
 tb/tb_box_shape_drawer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/box_shape_drawer_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display datapath: screen geometry, the drawer
// state encoding (also decoded by the controller FSM) and the on-screen test
// used by both the box drawer and the background-fill path.
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 180;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        DRAW   = 2'd2,
        DONE   = 2'd3
    } drawer_state_t;

    // Coordinates arrive zero-extended so callers with any X_W/Y_W can use it.
    function automatic logic pixel_visible(input logic [15:0] px, input logic [15:0] py);
        return (px < 16'(SCREEN_W)) && (py < 16'(SCREEN_H));
    endfunction

endpackage

// File: rtl/box_shape_drawer_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Nested column/row counter for rastering a W x H rectangle. dx advances
// every enabled cycle; on its wrap from W-1 to 0 dy advances.
// The next-state values are exported so a consumer can register an address
// derived from the pixel being entered this cycle.
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   clear         : force both counters to 0 (wins over enable)
//   enable        : advance one pixel
//   nxt_dx/nxt_dy : counter values after this edge
//   last          : current position is (W-1, H-1)
// -----------------------------------------------------------------------------
module raster_counter
    import display_pkg::*;
#(
    parameter int W = 20,
    parameter int H = 10,
    localparam int DX_W = (W > 1) ? $clog2(W) : 1,
    localparam int DY_W = (H > 1) ? $clog2(H) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [DX_W-1:0] nxt_dx,
    output logic [DY_W-1:0] nxt_dy,
    output logic            last
);

    logic [DX_W-1:0] dx_r;
    logic [DY_W-1:0] dy_r;
    logic            dx_end_s;
    logic            dy_end_s;

    assign dx_end_s = (dx_r == DX_W'(W - 1));
    assign dy_end_s = (dy_r == DY_W'(H - 1));
    assign last     = dx_end_s && dy_end_s;

    // Next-position logic: clear, row-major advance, or hold.
    always_comb begin
        nxt_dx = dx_r;
        nxt_dy = dy_r;
        if (clear) begin
            nxt_dx = {DX_W{1'b0}};
            nxt_dy = {DY_W{1'b0}};
        end else if (enable) begin
            if (dx_end_s) begin
                nxt_dx = {DX_W{1'b0}};
                if (dy_end_s) begin
                    nxt_dy = {DY_W{1'b0}};
                end else begin
                    nxt_dy = dy_r + DY_W'(1);
                end
            end else begin
                nxt_dx = dx_r + DX_W'(1);
                nxt_dy = dy_r;
            end
        end else begin
            nxt_dx = dx_r;
            nxt_dy = dy_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            dx_r <= {DX_W{1'b0}};
            dy_r <= {DY_W{1'b0}};
        end else begin
            dx_r <= nxt_dx;
            dy_r <= nxt_dy;
        end
    end

endmodule

// File: rtl/box_shape_drawer.sv
// -----------------------------------------------------------------------------
// box_shape_drawer
// Latches a box origin and colour, then rasters a filled BOX_W x BOX_H box
// into the frame buffer, one pixel per clock, followed by a one-cycle
// shapeDone pulse.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   loadStartAddress       : latch startX/startY and the selected colour
//   startingAddressLoaded  : begin drawing the latched box
//   startX, startY         : box top-left corner
//   noteActive             : selects fillColour (1) or emptyColour (0)
//   fillColour/emptyColour : candidate colours
//   x, y, colour, plot     : registered frame-buffer write port
//   shapeDone              : one-cycle pulse after the last pixel
//   busy                   : high in LOADED, DRAW and DONE
// -----------------------------------------------------------------------------
module box_shape_drawer
    import display_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 8,
    parameter int BOX_W    = 20,
    parameter int BOX_H    = 10,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                loadStartAddress,
    input  logic                startingAddressLoaded,
    input  logic [X_W-1:0]      startX,
    input  logic [Y_W-1:0]      startY,
    input  logic                noteActive,
    input  logic [COLOUR_W-1:0] fillColour,
    input  logic [COLOUR_W-1:0] emptyColour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                shapeDone,
    output logic                busy
);

    localparam int DX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int DY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    drawer_state_t       state_r;
    logic [X_W-1:0]      base_x_r;
    logic [Y_W-1:0]      base_y_r;
    logic [COLOUR_W-1:0] base_colour_r;

    logic                start_fire_s;
    logic                advance_s;
    logic [DX_W-1:0]     nxt_dx_s;
    logic [DY_W-1:0]     nxt_dy_s;
    logic                last_s;
    logic [X_W:0]        x_sum_s;
    logic [Y_W:0]        y_sum_s;
    logic                visible_s;

    // Counters are zeroed on the start edge so pixel (0,0) is registered
    // at that same edge; they then step on every DRAW cycle but the last.
    assign start_fire_s = (state_r == LOADED) && startingAddressLoaded;
    assign advance_s    = (state_r == DRAW) && !last_s;

    raster_counter #(
        .W (BOX_W),
        .H (BOX_H)
    ) u_raster (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_fire_s),
        .enable (advance_s),
        .nxt_dx (nxt_dx_s),
        .nxt_dy (nxt_dy_s),
        .last   (last_s)
    );

    // Address of the pixel being entered, one bit wider so the clip test
    // sees the true sum rather than a wrapped one.
    always_comb begin
        x_sum_s   = {1'b0, base_x_r} + (X_W + 1)'(nxt_dx_s);
        y_sum_s   = {1'b0, base_y_r} + (Y_W + 1)'(nxt_dy_s);
        visible_s = pixel_visible(16'(x_sum_s), 16'(y_sum_s));
    end

    // Drawer FSM and registered pixel-write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            base_x_r      <= {X_W{1'b0}};
            base_y_r      <= {Y_W{1'b0}};
            base_colour_r <= {COLOUR_W{1'b0}};
            x             <= {X_W{1'b0}};
            y             <= {Y_W{1'b0}};
            colour        <= {COLOUR_W{1'b0}};
            plot          <= 1'b0;
            shapeDone     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    plot      <= 1'b0;
                    shapeDone <= 1'b0;
                    if (loadStartAddress) begin
                        base_x_r      <= startX;
                        base_y_r      <= startY;
                        base_colour_r <= noteActive ? fillColour : emptyColour;
                        state_r       <= LOADED;
                        busy          <= 1'b1;
                    end
                end
                LOADED: begin
                    busy <= 1'b1;
                    // Start takes priority over a simultaneous re-load.
                    if (startingAddressLoaded) begin
                        state_r <= DRAW;
                        x       <= x_sum_s[X_W-1:0];
                        y       <= y_sum_s[Y_W-1:0];
                        colour  <= base_colour_r;
                        plot    <= visible_s;
                    end else if (loadStartAddress) begin
                        base_x_r      <= startX;
                        base_y_r      <= startY;
                        base_colour_r <= noteActive ? fillColour : emptyColour;
                    end
                end
                DRAW: begin
                    if (last_s) begin
                        state_r   <= DONE;
                        plot      <= 1'b0;
                        shapeDone <= 1'b1;
                    end else begin
                        x    <= x_sum_s[X_W-1:0];
                        y    <= y_sum_s[Y_W-1:0];
                        plot <= visible_s;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    shapeDone <= 1'b0;
                    busy      <= 1'b0;
                    plot      <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    plot      <= 1'b0;
                    shapeDone <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_box_shape_drawer.sv
// -----------------------------------------------------------------------------
// tb_box_shape_drawer
// Directed bench for box_shape_drawer with the default 20x10 box. Inputs are
// driven and outputs sampled on the falling edge; expected pixels come from
// a row-major formula over the cycle index after the start edge.
// -----------------------------------------------------------------------------
module tb_box_shape_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic       loadStartAddress;
    logic       startingAddressLoaded;
    logic [7:0] startX;
    logic [7:0] startY;
    logic       noteActive;
    logic [2:0] fillColour;
    logic [2:0] emptyColour;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       shapeDone;
    logic       busy;

    int n_vectors     = 0;
    int n_miscompares = 0;

    box_shape_drawer dut (
        .clock                 (clock),
        .reset                 (reset),
        .loadStartAddress      (loadStartAddress),
        .startingAddressLoaded (startingAddressLoaded),
        .startX                (startX),
        .startY                (startY),
        .noteActive            (noteActive),
        .fillColour            (fillColour),
        .emptyColour           (emptyColour),
        .x                     (x),
        .y                     (y),
        .colour                (colour),
        .plot                  (plot),
        .shapeDone             (shapeDone),
        .busy                  (busy)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors = n_vectors + 1;
        if (observed !== expected) begin
            n_miscompares = n_miscompares + 1;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Leaves the bench on a falling edge with the load already sampled.
    task automatic do_load(input int lx, input int ly, input logic na);
        @(negedge clock);
        loadStartAddress = 1'b1;
        startX           = 8'(lx);
        startY           = 8'(ly);
        noteActive       = na;
        @(negedge clock);
        loadStartAddress = 1'b0;
        check_value("busy_after_load", 32'(busy), 32'd1);
    endtask

    // Pulses start (optionally together with a conflicting load) and checks
    // cycles N+1 .. N+202 against the expected box at (x0,y0).
    task automatic run_box(input int x0, input int y0, input logic [2:0] col,
                           input bit with_load, input bit disturb,
                           output int nplots, output int ndone);
        int dx;
        int dy;
        bit vis;
        nplots = 0;
        ndone  = 0;
        startingAddressLoaded = 1'b1;
        if (with_load) begin
            loadStartAddress = 1'b1;
            startX           = 8'd100;
            startY           = 8'd100;
            noteActive       = ~noteActive;
        end
        for (int c = 1; c <= 202; c++) begin
            @(negedge clock);
            if (c == 1) begin
                startingAddressLoaded = 1'b0;
                loadStartAddress      = 1'b0;
            end
            if (plot) nplots++;
            if (shapeDone) ndone++;
            if (c <= 200) begin
                dx  = (c - 1) % 20;
                dy  = (c - 1) / 20;
                vis = ((x0 + dx) < 240) && ((y0 + dy) < 180);
                check_value("plot", 32'(plot), 32'(vis));
                check_value("busy_draw", 32'(busy), 32'd1);
                check_value("done_early", 32'(shapeDone), 32'd0);
                if (vis) begin
                    check_value("x", 32'(x), 32'(x0 + dx));
                    check_value("y", 32'(y), 32'(y0 + dy));
                    check_value("colour", 32'(colour), 32'(col));
                end
                // Inputs that must be ignored while drawing.
                if (disturb && c == 5) noteActive = ~noteActive;
                if (disturb && c == 10) begin
                    loadStartAddress      = 1'b1;
                    startingAddressLoaded = 1'b1;
                    startX                = 8'd77;
                    startY                = 8'd66;
                end
                if (disturb && c == 11) begin
                    loadStartAddress      = 1'b0;
                    startingAddressLoaded = 1'b0;
                end
            end else if (c == 201) begin
                check_value("done_pulse", 32'(shapeDone), 32'd1);
                check_value("plot_at_done", 32'(plot), 32'd0);
                check_value("busy_at_done", 32'(busy), 32'd1);
            end else begin
                check_value("done_cleared", 32'(shapeDone), 32'd0);
                check_value("busy_idle", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        int np;
        int nd;
        int tot_plots;
        int tot_done;

        reset                 = 1'b1;
        loadStartAddress      = 1'b0;
        startingAddressLoaded = 1'b0;
        startX                = 8'd0;
        startY                = 8'd0;
        noteActive            = 1'b0;
        fillColour            = 3'b010;
        emptyColour           = 3'b101;

        // Reset state.
        repeat (3) @(negedge clock);
        check_value("rst_x", 32'(x), 32'd0);
        check_value("rst_y", 32'(y), 32'd0);
        check_value("rst_colour", 32'(colour), 32'd0);
        check_value("rst_plot", 32'(plot), 32'd0);
        check_value("rst_done", 32'(shapeDone), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Start with no load in IDLE is ignored.
        @(negedge clock);
        startingAddressLoaded = 1'b1;
        @(negedge clock);
        startingAddressLoaded = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_value("idle_start_plot", 32'(plot), 32'd0);
            check_value("idle_start_busy", 32'(busy), 32'd0);
            @(negedge clock);
        end

        // Active note at (10,20).
        do_load(10, 20, 1'b1);
        run_box(10, 20, 3'b010, 1'b0, 1'b0, np, nd);
        check_value("box1_plots", 32'(np), 32'd200);
        check_value("box1_done", 32'(nd), 32'd1);

        // Inactive note, noteActive toggled and a load attempted mid-draw.
        emptyColour = 3'b000;
        fillColour  = 3'b111;
        do_load(50, 60, 1'b0);
        run_box(50, 60, 3'b000, 1'b0, 1'b1, np, nd);
        check_value("box2_plots", 32'(np), 32'd200);

        // Bottom-right corner: clipped to 10x5.
        do_load(230, 175, 1'b1);
        run_box(230, 175, 3'b111, 1'b0, 1'b0, np, nd);
        check_value("clip_plots", 32'(np), 32'd50);
        check_value("clip_done", 32'(nd), 32'd1);

        // Re-load in LOADED, then load+start together keeps the latched origin.
        do_load(5, 5, 1'b1);
        do_load(40, 50, 1'b0);
        run_box(40, 50, 3'b000, 1'b1, 1'b0, np, nd);
        check_value("ldst_plots", 32'(np), 32'd200);

        // Reset at the 50th plot cycle.
        do_load(10, 20, 1'b1);
        startingAddressLoaded = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clock);
            if (c == 1) startingAddressLoaded = 1'b0;
            if (c == 50) begin
                check_value("pre_rst_plot", 32'(plot), 32'd1);
                reset = 1'b1;
            end
            if (c == 51) begin
                check_value("post_rst_plot", 32'(plot), 32'd0);
                check_value("post_rst_busy", 32'(busy), 32'd0);
                reset = 1'b0;
            end
        end
        nd = 0;
        np = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clock);
            if (shapeDone) nd++;
            if (plot) np++;
        end
        check_value("rst_no_done", 32'(nd), 32'd0);
        check_value("rst_no_plot", 32'(np), 32'd0);
        check_value("rst_busy_low", 32'(busy), 32'd0);

        // Three back-to-back handshakes.
        tot_plots = 0;
        tot_done  = 0;
        for (int b = 0; b < 3; b++) begin
            do_load(40 * b, 0, 1'b1);
            run_box(40 * b, 0, 3'b111, 1'b0, 1'b0, np, nd);
            tot_plots += np;
            tot_done  += nd;
        end
        check_value("b2b_plots", 32'(tot_plots), 32'd600);
        check_value("b2b_done", 32'(tot_done), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
